vt_baudgen: RTL

VT_BAUDGEN -- requirements
Module: vt_baudgen

---
 rtl/vt_pkg.sv | 30 +++
 rtl/vt_tick_div16.sv | 40 ++++
 rtl/vt_baudgen.sv | 105 ++++++++++
 3 files changed

// File: rtl/vt_pkg.sv
// Shared terminal-timing definitions: speed codes, baud table and the
// divider / phase-increment calculations used by the UART and register blocks.
package vt_pkg;

    typedef logic [2:0] speed_t;

    localparam int unsigned NUM_SPEEDS = 8;
    localparam speed_t      SPEED_RESET = 3'b100;

    localparam int unsigned BAUD_TAB [NUM_SPEEDS] = '{
        1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200
    };

    // Integer oversample divider, rounded to nearest.
    function automatic longint unsigned calc_div(input longint unsigned clkfreq,
                                                 input speed_t          idx);
        longint unsigned b;
        b = 64'(BAUD_TAB[idx]);
        return (clkfreq + 64'd8 * b) / (64'd16 * b);
    endfunction

    // 32-bit phase increment giving 16*baud carries per second, rounded.
    function automatic longint unsigned calc_inc(input longint unsigned clkfreq,
                                                 input speed_t          idx);
        longint unsigned b;
        b = 64'(BAUD_TAB[idx]);
        return (((64'd16 * b) << 32) + (clkfreq >> 1)) / clkfreq;
    endfunction

endpackage

// File: rtl/vt_tick_div16.sv
// Divide-by-16 stage: turns the oversample strobe into the mid-bit sample
// pulse and the end-of-bit transmit strobe, both registered.
module vt_tick_div16
    import vt_pkg::*;
(
    input  logic wb_clk_i,
    input  logic wb_rst_n_i,
    input  logic tick16,
    input  logic clr,
    output logic tick_mid,
    output logic tick1
);

    logic [3:0] cnt_reg;
    logic       mid_reg;
    logic       one_reg;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cnt_reg <= 4'd0;
            mid_reg <= 1'b0;
            one_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg <= 4'd0;
            mid_reg <= 1'b0;
            one_reg <= 1'b0;
        end else begin
            // Pulses are registered alongside tick16 so all three line up.
            mid_reg <= tick16 && (cnt_reg == 4'd7);
            one_reg <= tick16 && (cnt_reg == 4'd15);
            if (tick16) begin
                cnt_reg <= cnt_reg + 4'd1;
            end
        end
    end

    assign tick_mid = mid_reg;
    assign tick1    = one_reg;

endmodule

// File: rtl/vt_baudgen.sv
// Terminal baud-rate generator. Define VT_BAUDGEN_FRAC_EN to replace the
// integer divider with a 32-bit phase accumulator.
module vt_baudgen
    import vt_pkg::*;
#(
    parameter int unsigned CLKFREQ = 50000000
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_n_i,
    input  logic [2:0] speed,
    input  logic       enable,
    output logic       tick16,
    output logic       tick_mid,
    output logic       tick1,
    output logic       speed_chg
);

    speed_t speed_q;
    logic   speed_chg_reg;
    logic   tick16_reg;
    logic   speed_chg_next;
    logic   clr;
    logic   rate_hit;
    logic   tick16_next;

    assign speed_chg_next = (speed != speed_q);
    // A speed change or disabled generator restarts everything this cycle.
    assign clr            = speed_chg_next || !enable;
    assign tick16_next    = rate_hit && !clr;

`ifdef VT_BAUDGEN_FRAC_EN
    logic [31:0] inc_tab [NUM_SPEEDS];
    logic [31:0] acc_reg;
    logic [32:0] acc_sum;

    for (genvar gi = 0; gi < NUM_SPEEDS; gi++) begin : g_inc
        localparam longint unsigned INC = calc_inc(64'(CLKFREQ), speed_t'(gi));
        if (INC >= 64'h8000_0000) begin : g_inc_err
            $error("vt_baudgen: phase increment too large for CLKFREQ");
        end
        assign inc_tab[gi] = INC[31:0];
    end

    assign acc_sum  = {1'b0, acc_reg} + {1'b0, inc_tab[speed_q]};
    assign rate_hit = acc_sum[32];

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            acc_reg <= 32'd0;
        end else if (clr) begin
            acc_reg <= 32'd0;
        end else begin
            acc_reg <= acc_sum[31:0];
        end
    end
`else
    logic [31:0] div_tab [NUM_SPEEDS];
    logic [31:0] cnt_reg;

    for (genvar gi = 0; gi < NUM_SPEEDS; gi++) begin : g_div
        localparam longint unsigned DIV = calc_div(64'(CLKFREQ), speed_t'(gi));
        if (DIV < 64'd2) begin : g_div_err
            $error("vt_baudgen: divider below 2 for CLKFREQ");
        end
        assign div_tab[gi] = DIV[31:0];
    end

    assign rate_hit = (cnt_reg == div_tab[speed_q] - 32'd1);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cnt_reg <= 32'd0;
        end else if (clr || rate_hit) begin
            cnt_reg <= 32'd0;
        end else begin
            cnt_reg <= cnt_reg + 32'd1;
        end
    end
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            speed_q       <= SPEED_RESET;
            speed_chg_reg <= 1'b0;
            tick16_reg    <= 1'b0;
        end else begin
            speed_q       <= speed;
            speed_chg_reg <= speed_chg_next;
            tick16_reg    <= tick16_next;
        end
    end

    vt_tick_div16 u_div16 (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .tick16     (tick16_next),
        .clr        (clr),
        .tick_mid   (tick_mid),
        .tick1      (tick1)
    );

    assign tick16    = tick16_reg;
    assign speed_chg = speed_chg_reg;

endmodule
